// File: rtl/dmi_arb_pkg.sv
// dmi_arb_pkg: shared widths, FSM state and latched-request types for the DMI request arbiter
package dmi_arb_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dmi_arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] wdata;
        logic                  lock;
    } dmi_arb_req_t;

endpackage

// File: rtl/dmi_req_arbiter_if.sv
// dmi_req_arbiter_if: one requester channel (request + response pulse); lock exists only with DMI_ARB_LOCK_EN
interface dmi_req_arbiter_if;
    import dmi_arb_pkg::*;

    logic                  valid;
    logic                  ready;
    logic                  wr;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
`ifdef DMI_ARB_LOCK_EN
    logic                  lock;
`endif
    logic                  rsp_valid;
    logic [DMI_DATA_W-1:0] rsp_rdata;

`ifdef DMI_ARB_LOCK_EN
    modport master (output valid, wr, addr, wdata, lock, input ready, rsp_valid, rsp_rdata);
    modport slave  (input valid, wr, addr, wdata, lock, output ready, rsp_valid, rsp_rdata);
`else
    modport master (output valid, wr, addr, wdata, input ready, rsp_valid, rsp_rdata);
    modport slave  (input valid, wr, addr, wdata, output ready, rsp_valid, rsp_rdata);
`endif

endinterface

// File: rtl/dmi_arb_rr.sv
// dmi_arb_rr: 2-way round-robin picker; prio=0 favours requester 0, mask removes requesters from contention
module dmi_arb_rr (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] v;

    assign v        = valid & mask;
    assign grant[0] = v[0] & (!v[1] | !prio);
    assign grant[1] = v[1] & (!v[0] |  prio);

endmodule

// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: round-robin sharing of one DMI upstream between two requesters; optional DMI_ARB_LOCK_EN grant lock
module dmi_req_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dmi_req_arbiter_if.slave      req0,
    dmi_req_arbiter_if.slave      req1,
    output logic                  dmi_en,
    output logic                  dmi_wr_en,
    output logic [DMI_ADDR_W-1:0] dmi_addr,
    output logic [DMI_DATA_W-1:0] dmi_wdata,
    input  logic [DMI_DATA_W-1:0] dmi_rdata,
    output logic                  busy
);

    dmi_arb_state_e                  state;
    dmi_arb_req_t                    req_q;
    dmi_arb_req_t                    req_in;
    logic [1:0]                      valid;
    logic [1:0]                      grant;
    logic [1:0]                      mask;
    logic [1:0]                      ready;
    logic                            accept;
    logic                            win;
    logic                            win_q;
    logic                            prio;
    logic                            owner_v;
    logic [2:0]                      cnt;
    logic [1:0]                      rsp_valid;
    logic [1:0][DMI_DATA_W-1:0]      rsp_rdata;

    assign valid  = {req1.valid, req0.valid};
    assign ready  = (state == IDLE) ? grant : 2'b00;
    assign accept = |ready;
    assign win    = grant[1];
    assign busy   = state != IDLE;

    assign req0.ready     = ready[0];
    assign req1.ready     = ready[1];
    assign req0.rsp_valid = rsp_valid[0];
    assign req1.rsp_valid = rsp_valid[1];
    assign req0.rsp_rdata = rsp_rdata[0];
    assign req1.rsp_rdata = rsp_rdata[1];

    assign dmi_addr  = req_q.addr;
    assign dmi_wdata = req_q.wdata;

    assign req_in.wr    = win ? req1.wr    : req0.wr;
    assign req_in.addr  = win ? req1.addr  : req0.addr;
    assign req_in.wdata = win ? req1.wdata : req0.wdata;

`ifdef DMI_ARB_LOCK_EN
    logic owner_id;

    assign req_in.lock = win ? req1.lock : req0.lock;
    assign mask        = owner_v ? (owner_id ? 2'b10 : 2'b01) : 2'b11;

    // lock owner: set on a locking accept, released after the owner's unlocking transaction responds
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_v  <= 1'b0;
            owner_id <= 1'b0;
        end else if (accept && req_in.lock) begin
            owner_v  <= 1'b1;
            owner_id <= win;
        end else if (state == RESP && !req_q.lock) begin
            owner_v  <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign req_in.lock = 1'b0;
    assign owner_v     = 1'b0;
    assign mask        = 2'b11;
    assign unused_lock = req_q.lock;
`endif

    dmi_arb_rr u_rr (
        .valid (valid),
        .prio  (prio),
        .mask  (mask),
        .grant (grant)
    );

    // round-robin pointer: hand priority to the other requester after each grant, frozen while locked
    always_ff @(posedge clk) begin
        if (rst) prio <= 1'b0;
        else if (accept && !owner_v) prio <= ~win;
    end

    // transaction FSM: accept, one-cycle strobe, fixed read latency, one-cycle response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            win_q     <= 1'b0;
            cnt       <= '0;
            dmi_en    <= 1'b0;
            dmi_wr_en <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            dmi_en    <= 1'b0;
            dmi_wr_en <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (accept) begin
                    req_q     <= req_in;
                    win_q     <= win;
                    dmi_en    <= 1'b1;
                    dmi_wr_en <= req_in.wr;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= 3'(RD_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    rsp_rdata[win_q] <= req_q.wr ? '0 : dmi_rdata;
                    rsp_valid        <= win_q ? 2'b10 : 2'b01;
                    state            <= RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                RESP: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// tb_dmi_req_arbiter: directed checks of dmi_req_arbiter (RD_LATENCY 1 and 3); honours DMI_ARB_LOCK_EN
module tb_dmi_req_arbiter;
    import dmi_arb_pkg::*;

    localparam logic [31:0] JUNK = 32'h0BAD0BAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmi_req_arbiter_if a0 ();
    dmi_req_arbiter_if a1 ();
    dmi_req_arbiter_if b0 ();
    dmi_req_arbiter_if b1 ();

    logic        en_a, wr_a, busy_a, en_b, wr_b, busy_b;
    logic [6:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b;

    dmi_req_arbiter #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .req0(a0), .req1(a1),
        .dmi_en(en_a), .dmi_wr_en(wr_a), .dmi_addr(addr_a), .dmi_wdata(wdata_a),
        .dmi_rdata(rdata_a), .busy(busy_a)
    );

    dmi_req_arbiter #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .req0(b0), .req1(b1),
        .dmi_en(en_b), .dmi_wr_en(wr_b), .dmi_addr(addr_b), .dmi_wdata(wdata_b),
        .dmi_rdata(rdata_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear();
        a0.valid = 0; a0.wr = 0; a0.addr = '0; a0.wdata = '0;
        a1.valid = 0; a1.wr = 0; a1.addr = '0; a1.wdata = '0;
        b0.valid = 0; b0.wr = 0; b0.addr = '0; b0.wdata = '0;
        b1.valid = 0; b1.wr = 0; b1.addr = '0; b1.wdata = '0;
`ifdef DMI_ARB_LOCK_EN
        a0.lock = 0; a1.lock = 0; b0.lock = 0; b1.lock = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 20 && id < 0; i++) begin
            #1;
            if (a0.ready || a1.ready) id = a1.ready ? 1 : 0;
            else @(negedge clk);
        end
    endtask

    int id, last, n0;
    int exp6 [4];

    initial begin
        clear();
        rdata_a = JUNK;
        rdata_b = JUNK;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_en", en_a, 0);
        check("rst_rsp", {a1.rsp_valid, a0.rsp_valid}, 0);
        check("rst_addr", addr_a, 0);
        check("rst_rdata0", a0.rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: req0 read, latency 1
        a0.valid = 1; a0.addr = 7'h04; #1;
        check("t1_ready0", a0.ready, 1);
        check("t1_ready1", a1.ready, 0);
        @(negedge clk); a0.valid = 0;
        check("t1_en", en_a, 1);
        check("t1_wr_en", wr_a, 0);
        check("t1_addr", addr_a, 7'h04);
        check("t1_busy", busy_a, 1);
        @(negedge clk); rdata_a = 32'hDEADBEEF;
        check("t1_en_off", en_a, 0);
        check("t1_rsp_early", a0.rsp_valid, 0);
        @(negedge clk); rdata_a = JUNK;
        check("t1_rsp0", a0.rsp_valid, 1);
        check("t1_rdata0", a0.rsp_rdata, 32'hDEADBEEF);
        check("t1_rsp1", a1.rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp0_pulse", a0.rsp_valid, 0);
        check("t1_idle", busy_a, 0);
        check("t1_rdata_hold", a0.rsp_rdata, 32'hDEADBEEF);

        // 2: req1 write
        a1.valid = 1; a1.wr = 1; a1.addr = 7'h5A; a1.wdata = 32'h12345678; #1;
        check("t2_ready1", a1.ready, 1);
        check("t2_ready0", a0.ready, 0);
        @(negedge clk); a1.valid = 0; a1.wr = 0;
        check("t2_en", en_a, 1);
        check("t2_wr_en", wr_a, 1);
        check("t2_addr", addr_a, 7'h5A);
        check("t2_wdata", wdata_a, 32'h12345678);
        @(negedge clk);
        check("t2_en_off", {en_a, wr_a}, 0);
        @(negedge clk);
        check("t2_rsp1", a1.rsp_valid, 1);
        check("t2_rdata1", a1.rsp_rdata, 0);
        check("t2_rsp0", a0.rsp_valid, 0);
        @(negedge clk);
        check("t2_addr_hold", addr_a, 7'h5A);

        // 4: req0 read, latency 3, data valid only on the capture cycle
        b0.valid = 1; b0.addr = 7'h33; #1;
        check("t4_ready", b0.ready, 1);
        @(negedge clk); b0.valid = 0;
        check("t4_en", en_b, 1);
        @(negedge clk);
        @(negedge clk);
        check("t4_rsp_early3", b0.rsp_valid, 0);
        @(negedge clk); rdata_b = 32'hAAAA0000;
        check("t4_rsp_early4", b0.rsp_valid, 0);
        @(negedge clk); rdata_b = JUNK;
        check("t4_rsp", b0.rsp_valid, 1);
        check("t4_rdata", b0.rsp_rdata, 32'hAAAA0000);
        @(negedge clk);
        check("t4_idle", busy_b, 0);

        // 3: both valid from reset alternate 0,1,0,1 every 4 cycles
        do_reset();
        a0.valid = 1; a0.addr = 7'h10;
        a1.valid = 1; a1.addr = 7'h20;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(id);
            check("t3_grant", id, k % 2);
            check("t3_excl", {31'd0, a0.ready & a1.ready}, 0);
            if (k > 0) check("t3_gap", cyc - last, 4);
            last = cyc;
            @(negedge clk);
            check("t3_en", en_a, 1);
            check("t3_addr", addr_a, (k % 2) ? 7'h20 : 7'h10);
            check("t3_ready_pulse", {a1.ready, a0.ready}, 0);
        end
        clear();
        repeat (4) @(negedge clk);

        // 5: reset in WAIT aborts, then a req1 read completes
        a0.valid = 1; a0.addr = 7'h44; #1;
        check("t5_ready0", a0.ready, 1);
        @(negedge clk); a0.valid = 0;
        @(negedge clk); rst = 1'b1;
        check("t5_in_wait", busy_a, 1);
        @(negedge clk); rst = 1'b0;
        check("t5_busy", busy_a, 0);
        check("t5_en", {en_a, wr_a}, 0);
        check("t5_rsp", {a1.rsp_valid, a0.rsp_valid}, 0);
        check("t5_rdata0", a0.rsp_rdata, 0);
        check("t5_addr", addr_a, 0);
        @(negedge clk);
        check("t5_no_rsp", a0.rsp_valid, 0);
        a1.valid = 1; a1.addr = 7'h11; #1;
        check("t5_ready1", a1.ready, 1);
        @(negedge clk); a1.valid = 0;
        check("t5_en1", en_a, 1);
        @(negedge clk);
        @(negedge clk);
        check("t5_rsp1", a1.rsp_valid, 1);
        check("t5_rdata1", a1.rsp_rdata, JUNK);
        @(negedge clk);

        // 6: req0 lock 1,1,0 with req1 waiting
`ifdef DMI_ARB_LOCK_EN
        exp6 = '{0, 0, 0, 1};
`else
        exp6 = '{0, 1, 0, 1};
`endif
        do_reset();
        n0 = 0;
        a0.valid = 1; a0.addr = 7'h01;
        a1.valid = 1; a1.addr = 7'h02;
`ifdef DMI_ARB_LOCK_EN
        a0.lock = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            wait_grant(id);
            check("t6_grant", id, exp6[k]);
            @(negedge clk);
            if (id == 0) begin
                n0++;
`ifdef DMI_ARB_LOCK_EN
                a0.lock = n0 < 2;
`endif
                if (n0 == 3) a0.valid = 0;
            end
        end
        clear();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
